mem_port_arbiter: RTL and testbench

Two-requester controller for the processor's single-ported, byte-addressed unified memory (64 KiB, little-endian word assembly). It arbitrates between the instruction-fetch port and the data load/store port and sequences each multi-cycle memory access. It returns read data to the winning requester with a one-cycle acknowledge. It sits between the fetch/execute stages and the memory array; the core stalls a stage while its request is pending without an acknowledge.

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bundle for mem_port_arbiter.
// slave = arbiter view, master = requesters plus memory array view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 16
);
  logic          i_req;
  logic [31:0]   i_adr;
  logic [31:0]   i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_we;
  logic [31:0]   d_adr;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_ack;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_adr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  modport slave (
    input  i_req, i_adr, d_req, d_we,
    input  d_adr, d_wdata, m_rdata,
    output i_rdata, i_ack, d_rdata, d_ack,
    output m_en, m_we, m_adr, m_wdata
  );

  modport master (
    output i_req, i_adr, d_req, d_we,
    output d_adr, d_wdata, m_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack,
    input  m_en, m_we, m_adr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter and access sequencer for the unified memory.
// Define ARB_FAIR_EN to build the fetch-starvation guard.
module mem_port_arbiter #(
  parameter int unsigned LAT = 2,
  parameter int unsigned AW  = 16
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          own_q, own_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          grant;
  logic          pick_d;
  logic          force_i;
  logic          unused_adr;

  assign unused_adr = ^{bus.i_adr[31:AW], bus.i_adr[1:0],
                        bus.d_adr[31:AW], bus.d_adr[1:0]};

`ifdef ARB_FAIR_EN
  logic [2:0] fair_q, fair_d;

  assign force_i = (fair_q == 3'd4);

  // Counts data wins over a waiting fetch.
  always_comb begin
    fair_d = fair_q;
    if (grant) begin
      if (!pick_d) begin
        fair_d = 3'd0;
      end else if (bus.i_req) begin
        fair_d = fair_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fair_q <= 3'd0;
    end else begin
      fair_q <= fair_d;
    end
  end
`else
  assign force_i = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    own_d     = own_q;
    adr_d     = adr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    grant     = 1'b0;
    pick_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant  = bus.i_req | bus.d_req;
        pick_d = bus.d_req & ~(bus.i_req & force_i);
        if (grant) begin
          state_d = ACCESS;
          cnt_d   = CNT_INIT;
          own_d   = pick_d;
          adr_d   = pick_d ? {bus.d_adr[AW-1:2], 2'b00}
                           : {bus.i_adr[AW-1:2], 2'b00};
          we_d    = pick_d & bus.d_we;
          wdata_d = pick_d ? bus.d_wdata : 32'd0;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (!we_q) begin
            if (own_q) begin
              d_rdata_d = bus.m_rdata;
            end else begin
              i_rdata_d = bus.m_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      own_q     <= 1'b0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      wdata_q   <= 32'd0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      own_q     <= own_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Memory strobes are decoded straight from state so reset kills them at once.
  assign bus.m_en    = (state_q == ACCESS);
  assign bus.m_we    = bus.m_en & we_q;
  assign bus.m_adr   = bus.m_en ? adr_q : '0;
  assign bus.m_wdata = bus.m_en ? wdata_q : 32'd0;
  assign bus.i_ack   = (state_q == RESP) & ~own_q;
  assign bus.d_ack   = (state_q == RESP) & own_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter.
// Covers LAT=2 main instance and a LAT=1 instance.
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb[$];

  logic [31:0] mem [16384];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.AW(16)) bus ();
  mem_port_arbiter_if #(.AW(16)) bus1 ();

  mem_port_arbiter #(.LAT(2), .AW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_port_arbiter #(.LAT(1), .AW(16)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  assign bus.m_rdata  = mem[bus.m_adr[15:2]];
  assign bus1.m_rdata = {16'hBEEF, bus1.m_adr};

  always @(posedge clk) begin
    if (bus.m_en && bus.m_we) mem[bus.m_adr[15:2]] <= bus.m_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit is_d, input int t0, input int exp_cyc,
                          output int en_n, output int we_n,
                          output logic [15:0] adr_seen);
    bit   got;
    exp_t e;
    got = 1'b0;
    en_n = 0;
    we_n = 0;
    adr_seen = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.m_en) begin
        en_n++;
        adr_seen = bus.m_adr;
      end
      if (bus.m_we) we_n++;
      if (is_d ? bus.d_ack : bus.i_ack) begin
        got = 1'b1;
        chk("ack_cycle", cyc - t0, exp_cyc);
        chk("ack_excl", {31'd0, bus.i_ack & bus.d_ack}, 32'd0);
        e = sb.pop_front();
        chk("ack_port", {31'd0, is_d}, {31'd0, e.is_d});
        chk("rdata", is_d ? bus.d_rdata : bus.i_rdata, e.data);
      end
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
  endtask

  initial begin
    int          t0;
    int          en_n;
    int          we_n;
    logic [15:0] adr_seen;
    logic [31:0] d_model;
    bit          hit;
    bit          who;
    int          n_tr;
    int          bad;
    int          ack_c;

    rst = 1'b0;
    {bus.i_req, bus.d_req, bus.d_we} = '0;
    {bus.i_adr, bus.d_adr, bus.d_wdata} = '0;
    {bus1.i_req, bus1.d_req, bus1.d_we} = '0;
    {bus1.i_adr, bus1.d_adr, bus1.d_wdata} = '0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
    mem[0] = 32'h2401_0010;
    mem[1] = 32'h1111_2222;
    mem[2] = 32'hCAFE_0008;
    d_model = 32'd0;

    repeat (3) sync();
    chk("rst_i_ack", {31'd0, bus.i_ack}, 32'd0);
    chk("rst_d_ack", {31'd0, bus.d_ack}, 32'd0);
    chk("rst_m_en", {31'd0, bus.m_en}, 32'd0);
    chk("rst_m_we", {31'd0, bus.m_we}, 32'd0);
    chk("rst_m_adr", {16'd0, bus.m_adr}, 32'd0);
    chk("rst_m_wdata", bus.m_wdata, 32'd0);
    chk("rst_i_rdata", bus.i_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    sync();

    // single fetch
    t0 = cyc;
    bus.i_req = 1'b1;
    bus.i_adr = 32'd0;
    sb.push_back('{is_d: 1'b0, data: 32'h2401_0010});
    wait_ack(1'b0, t0, 3, en_n, we_n, adr_seen);
    bus.i_req = 1'b0;
    chk("fetch_en_cycles", en_n, 2);
    chk("fetch_we_cycles", we_n, 0);
    chk("fetch_m_adr", {16'd0, adr_seen}, 32'd0);
    sync();

    // store 8 to 2000
    t0 = cyc;
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_adr = 32'd2000;
    bus.d_wdata = 32'd8;
    sb.push_back('{is_d: 1'b1, data: d_model});
    wait_ack(1'b1, t0, 3, en_n, we_n, adr_seen);
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    chk("store_we_cycles", we_n, 2);
    chk("store_m_adr", {16'd0, adr_seen}, 32'd2000);
    sync();

    // load back from 2000
    t0 = cyc;
    bus.d_req = 1'b1;
    bus.d_adr = 32'd2000;
    d_model = 32'd8;
    sb.push_back('{is_d: 1'b1, data: d_model});
    wait_ack(1'b1, t0, 3, en_n, we_n, adr_seen);
    bus.d_req = 1'b0;
    chk("load_we_cycles", we_n, 0);
    sync();

    // contention: data first, fetch in the next IDLE
    t0 = cyc;
    bus.d_req = 1'b1;
    bus.d_adr = 32'd8;
    bus.i_req = 1'b1;
    bus.i_adr = 32'd4;
    d_model = 32'hCAFE_0008;
    sb.push_back('{is_d: 1'b1, data: d_model});
    sb.push_back('{is_d: 1'b0, data: 32'h1111_2222});
    wait_ack(1'b1, t0, 3, en_n, we_n, adr_seen);
    bus.d_req = 1'b0;
    chk("cont_d_adr", {16'd0, adr_seen}, 32'd8);
    wait_ack(1'b0, t0, 7, en_n, we_n, adr_seen);
    bus.i_req = 1'b0;
    chk("cont_i_adr", {16'd0, adr_seen}, 32'd4);
    sync();

    // both requests held continuously
`ifdef ARB_FAIR_EN
    n_tr = 25;
`else
    n_tr = 50;
`endif
    bus.d_req = 1'b1;
    bus.i_req = 1'b1;
    bad = 0;
    ack_c = 0;
    for (int k = 0; k < n_tr; k++) begin
      hit = 1'b0;
      who = 1'b0;
      for (int c = 0; c < 10 && !hit; c++) begin
        @(negedge clk);
        if (bus.i_ack || bus.d_ack) begin
          hit = 1'b1;
          who = bus.i_ack;
          if (bus.i_ack) ack_c++;
        end
      end
      if (!hit) bad++;
`ifdef ARB_FAIR_EN
      chk("starve_owner", {31'd0, who}, {31'd0, (k % 5) == 4});
`else
      chk("starve_owner", {31'd0, who}, 32'd0);
`endif
    end
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    chk("starve_timeouts", bad, 0);
`ifdef ARB_FAIR_EN
    chk("starve_i_acks", ack_c, n_tr / 5);
`else
    chk("starve_i_acks", ack_c, 0);
`endif
    sync();

    // reset in the second ACCESS cycle of a store
    t0 = cyc;
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_adr = 32'h100;
    bus.d_wdata = 32'h55;
    repeat (3) @(negedge clk);
    chk("abort_pre_we", {31'd0, bus.m_we}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_m_we", {31'd0, bus.m_we}, 32'd0);
    chk("abort_m_en", {31'd0, bus.m_en}, 32'd0);
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    d_model = 32'd0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.d_ack || bus.m_en || bus.m_we) bad++;
    end
    chk("abort_quiet", bad, 0);
    chk("abort_d_rdata", bus.d_rdata, d_model);
    sync();
    t0 = cyc;
    bus.d_req = 1'b1;
    bus.d_adr = 32'd2000;
    d_model = 32'd8;
    sb.push_back('{is_d: 1'b1, data: d_model});
    wait_ack(1'b1, t0, 3, en_n, we_n, adr_seen);
    bus.d_req = 1'b0;
    sync();

    // LAT=1 fetch with misaligned, high-bit-polluted address
    t0 = cyc;
    bus1.i_req = 1'b1;
    bus1.i_adr = 32'hABCD_0013;
    en_n = 0;
    adr_seen = '0;
    hit = 1'b0;
    ack_c = -1;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clk);
      if (bus1.m_en) begin
        en_n++;
        adr_seen = bus1.m_adr;
      end
      if (bus1.i_ack) begin
        hit = 1'b1;
        ack_c = cyc - t0;
        chk("lat1_rdata", bus1.i_rdata, 32'hBEEF_0010);
      end
    end
    bus1.i_req = 1'b0;
    chk("lat1_ack_cycle", ack_c, 2);
    chk("lat1_en_cycles", en_n, 1);
    chk("lat1_m_adr", {16'd0, adr_seen}, 32'h10);
    chk("sb_empty", sb.size(), 0);
    sync();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
